// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// exc_valid exists only when MC_EXCEPT_EN is defined.
interface multicycle_control_if #(
  parameter int unsigned OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
`ifdef MC_EXCEPT_EN
  logic           exc_valid;
`endif
  logic           pc_write;
  logic           pc_write_cond;
  logic           i_or_d;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_source;
  logic [3:0]     state;
  logic           instr_done;

  modport master (
    input  opcode, input mem_ready,
`ifdef MC_EXCEPT_EN
    output exc_valid,
`endif
    output pc_write, output pc_write_cond, output i_or_d, output mem_read,
    output mem_write, output ir_write, output mem_to_reg, output reg_dst,
    output reg_write, output alu_src_a, output alu_src_b, output alu_op,
    output pc_source, output state, output instr_done
  );

  modport slave (
    output opcode, output mem_ready,
`ifdef MC_EXCEPT_EN
    input  exc_valid,
`endif
    input  pc_write, input pc_write_cond, input i_or_d, input mem_read,
    input  mem_write, input ir_write, input mem_to_reg, input reg_dst,
    input  reg_write, input alu_src_a, input alu_src_b, input alu_op,
    input  pc_source, input state, input instr_done
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with mem_ready stalls. Define MC_EXCEPT_EN to trap unknown opcodes to EXCEPT.
module multicycle_control #(
  parameter int unsigned    OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OPW-1:0] OP_LW    = 6'b100011,
  parameter logic [OPW-1:0] OP_SW    = 6'b101011,
  parameter logic [OPW-1:0] OP_BEQ   = 6'b000100,
  parameter logic [OPW-1:0] OP_ADDI  = 6'b001000,
  parameter logic [OPW-1:0] OP_J     = 6'b000010,
  parameter bit             MEM_WAIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus
);
  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MC_EXCEPT_EN
    , S_EXCEPT = 4'd12
`endif
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_is_store;
  logic   w_mem_ok;

  // Memory handshake is bypassed entirely for single-cycle memories.
  assign w_mem_ok  = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign bus.state = r_state;

  // State register; load/store choice is latched in DECODE so MEMADR ignores later opcode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_store <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
`ifdef MC_EXCEPT_EN
    bus.exc_valid     = 1'b0;
`endif
    // Reset masks every strobe; the register handles the return to FETCH.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (w_mem_ok) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            w_next       = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next = S_MEMADR;
          else if (bus.opcode == OP_RTYPE)                w_next = S_EXEC;
          else if (bus.opcode == OP_BEQ)                  w_next = S_BRANCH;
          else if (bus.opcode == OP_ADDI)                 w_next = S_ADDIEX;
          else if (bus.opcode == OP_J)                    w_next = S_JUMP;
          else begin
`ifdef MC_EXCEPT_EN
            w_next = S_EXCEPT;
`else
            bus.instr_done = 1'b1;
            w_next         = S_FETCH;
`endif
          end
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          w_next        = r_is_store ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (w_mem_ok) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = S_FETCH;
        end
        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (w_mem_ok) begin
            bus.instr_done = 1'b1;
            w_next         = S_FETCH;
          end
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
          w_next        = S_ALUWB;
        end
        S_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
          bus.instr_done    = 1'b1;
          w_next            = S_FETCH;
        end
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          w_next        = S_ADDIWB;
        end
        S_ADDIWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          bus.instr_done = 1'b1;
          w_next         = S_FETCH;
        end
`ifdef MC_EXCEPT_EN
        S_EXCEPT: begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b11;
          bus.instr_done = 1'b1;
          bus.exc_valid  = 1'b1;
          w_next         = S_FETCH;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and packed control
// vector against hand-written expectations; honours MC_EXCEPT_EN.
module tb_multicycle_control;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  multicycle_control_if #(.OPW(6)) bus ();
  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs controls as {pw,pwc,iod,mr,mw,irw,m2r,rdst,rw,asa,asb,aop,psrc,done}.
  function automatic logic [16:0] ov(input logic pw, pwc, iod, mr, mw, irw,
                                     m2r, rdst, rw, asa, input logic [1:0] asb,
                                     aop, psrc, input logic done);
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check state/controls mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [16:0] ex);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".ctl"}, 32'(observed()), 32'(ex));
`ifdef MC_EXCEPT_EN
    check({tag, ".exc"}, 32'(bus.exc_valid), 32'(st == 4'd12 && !rst));
`endif
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010,
                         BAD = 6'b111111;

  logic [16:0] c_zero, c_fetch, c_fstall, c_dec, c_madr, c_mrd, c_mwb;
  logic [16:0] c_mwr, c_mwrst, c_exec, c_aluwb, c_br, c_aiex, c_aiwb, c_jmp;
  logic [16:0] c_dec_nop, c_exc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    c_zero    = '0;
    c_fetch   = ov(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_fstall  = ov(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_dec     = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    c_dec_nop = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    c_madr    = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_mrd     = ov(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_mwb     = ov(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1);
    c_mwr     = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1);
    c_mwrst   = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_exec    = ov(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    c_aluwb   = ov(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1);
    c_br      = ov(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1);
    c_aiex    = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_aiwb    = ov(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1);
    c_jmp     = ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1);
    c_exc     = ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,1);

    rst = 1'b1;
    bus.opcode    = RT;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst0", RT, 1, 4'd0, c_zero);
    cyc("rst1", RT, 1, 4'd0, c_zero);
    rst = 1'b0;

    // R-type, 4 cycles
    cyc("rt.f",  RT, 1, 4'd0, c_fetch);
    cyc("rt.d",  RT, 1, 4'd1, c_dec);
    cyc("rt.ex", LW, 0, 4'd6, c_exec);
    cyc("rt.wb", LW, 0, 4'd7, c_aluwb);

    // lw with 3 stall cycles in MEMRD; opcode/mem_ready changes in MEMADR ignored
    cyc("lw.f",  LW, 1, 4'd0, c_fetch);
    cyc("lw.d",  LW, 1, 4'd1, c_dec);
    cyc("lw.ma", SW, 0, 4'd2, c_madr);
    cyc("lw.r0", SW, 0, 4'd3, c_mrd);
    cyc("lw.r1", SW, 0, 4'd3, c_mrd);
    cyc("lw.r2", SW, 0, 4'd3, c_mrd);
    cyc("lw.r3", SW, 1, 4'd3, c_mrd);
    cyc("lw.wb", SW, 0, 4'd4, c_mwb);

    // sw / beq / j back-to-back
    cyc("sw.f",  SW, 1, 4'd0, c_fetch);
    cyc("sw.d",  SW, 1, 4'd1, c_dec);
    cyc("sw.ma", LW, 1, 4'd2, c_madr);
    cyc("sw.wr", LW, 1, 4'd5, c_mwr);
    cyc("bq.f",  BQ, 1, 4'd0, c_fetch);
    cyc("bq.d",  BQ, 1, 4'd1, c_dec);
    cyc("bq.br", BQ, 1, 4'd8, c_br);
    cyc("j.f",   JJ, 1, 4'd0, c_fetch);
    cyc("j.d",   JJ, 1, 4'd1, c_dec);
    cyc("j.jp",  JJ, 1, 4'd11, c_jmp);

    // addi, with a one-cycle fetch stall
    cyc("ai.fs", AI, 0, 4'd0, c_fstall);
    cyc("ai.f",  AI, 1, 4'd0, c_fetch);
    cyc("ai.d",  AI, 1, 4'd1, c_dec);
    cyc("ai.ex", AI, 1, 4'd9, c_aiex);
    cyc("ai.wb", AI, 1, 4'd10, c_aiwb);

    // sw with one stall cycle in MEMWR
    cyc("sws.f",  SW, 1, 4'd0, c_fetch);
    cyc("sws.d",  SW, 1, 4'd1, c_dec);
    cyc("sws.ma", SW, 1, 4'd2, c_madr);
    cyc("sws.w0", SW, 0, 4'd5, c_mwrst);
    cyc("sws.w1", SW, 1, 4'd5, c_mwr);

    // reset in MEMRD of a lw abandons it
    cyc("rl.f",  LW, 1, 4'd0, c_fetch);
    cyc("rl.d",  LW, 1, 4'd1, c_dec);
    cyc("rl.ma", LW, 1, 4'd2, c_madr);
    rst = 1'b1;
    cyc("rl.rd", LW, 1, 4'd3, c_zero);
    cyc("rl.r1", LW, 1, 4'd0, c_zero);
    rst = 1'b0;
    cyc("rl.f2", RT, 1, 4'd0, c_fetch);
    cyc("rl.d2", RT, 1, 4'd1, c_dec);
    cyc("rl.ex", RT, 1, 4'd6, c_exec);
    cyc("rl.wb", RT, 1, 4'd7, c_aluwb);

    // illegal opcode
    cyc("il.f", BAD, 1, 4'd0, c_fetch);
`ifdef MC_EXCEPT_EN
    cyc("il.d",  BAD, 1, 4'd1, c_dec);
    cyc("il.ex", BAD, 1, 4'd12, c_exc);
`else
    cyc("il.d",  BAD, 1, 4'd1, c_dec_nop);
`endif
    cyc("il.f2", RT, 1, 4'd0, c_fetch);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
